// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter between the instruction-fetch and data ports
// of a small RISC-V core. Data accesses normally win. A saturating counter
// tracks how many data grants were made while a fetch was waiting. When that
// counter reaches STARVE_MAX, the next contested grant goes to fetch.
//
// Handshake: a request is accepted in the cycle where both its req and its
// ready are high. ready is a one-cycle grant pulse, and the requester holds
// req and its payload until that pulse. The matching valid follows exactly
// one cycle after the grant and cannot be back-pressured. Both readies stay
// low while a response is in flight, so there is at most one access every
// two cycles.
module riscv_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            if_req,
  input  logic [XLEN-1:0]                 if_addr,
  output logic                            if_ready,
  output logic                            if_valid,
  output logic [XLEN-1:0]                 if_data,
  input  logic                            d_req,
  input  logic                            d_write,
  input  logic [XLEN-1:0]                 d_addr,
  input  logic [XLEN-1:0]                 d_wdata,
  output logic                            d_ready,
  output logic                            d_valid,
  output logic [XLEN-1:0]                 d_rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [XLEN-1:0]                 mem_addr,
  output logic [XLEN-1:0]                 mem_wdata,
  input  logic [XLEN-1:0]                 mem_rdata,
  output logic                            stall,
  output logic [1:0]                      dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0] dbg_starve_cnt
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             wr_q, wr_d;
  logic             grant_i, grant_d;

  // State, starvation counter and latched store flag; reset drops any response in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
    end
  end

  // Arbitration, next state and all outputs; every output is forced low during reset
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    wr_d           = wr_q;
    grant_i        = 1'b0;
    grant_d        = 1'b0;
    if_ready       = 1'b0;
    if_valid       = 1'b0;
    if_data        = '0;
    d_ready        = 1'b0;
    d_valid        = 1'b0;
    d_rdata        = '0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    stall          = 1'b0;
    dbg_state      = state_q;
    dbg_starve_cnt = starve_q;

    case (state_q)
      IDLE: begin
        // Fetch wins only when data is absent or fetch has waited long enough
        grant_i = if_req && (!d_req || (starve_q == STARVE_LIM));
        grant_d = d_req && !grant_i;
        if (grant_i) begin
          if_ready = 1'b1;
          mem_en   = 1'b1;
          mem_addr = if_addr;
          starve_d = '0;
          state_d  = RESP_I;
        end else if (grant_d) begin
          d_ready   = 1'b1;
          mem_en    = 1'b1;
          mem_we    = d_write;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          wr_d      = d_write;
          state_d   = RESP_D;
          if (if_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      RESP_I: begin
        if_valid = 1'b1;
        if_data  = mem_rdata;
        state_d  = IDLE;
      end
      RESP_D: begin
        d_valid = 1'b1;
        d_rdata = wr_q ? '0 : mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    stall = if_req && !if_ready;

    if (rst) begin
      if_ready       = 1'b0;
      if_valid       = 1'b0;
      if_data        = '0;
      d_ready        = 1'b0;
      d_valid        = 1'b0;
      d_rdata        = '0;
      mem_en         = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      stall          = 1'b0;
      dbg_state      = 2'd0;
      dbg_starve_cnt = '0;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter. It provides a behavioural memory, an
// independent arbitration model, and a response scoreboard. Directed
// sequences target the documented corner cases. A random phase follows.
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;

  localparam int XLEN = 32;
  localparam int SM   = 3;
  localparam int CW   = $clog2(SM + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            if_req = 1'b0, d_req = 1'b0, d_write = 1'b0;
  logic [XLEN-1:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic            if_ready, if_valid, d_ready, d_valid;
  logic [XLEN-1:0] if_data, d_rdata;
  logic            mem_en, mem_we, stall;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [XLEN-1:0] mem_rdata = '0;
  logic [1:0]      dbg_state;
  logic [CW-1:0]   dbg_starve_cnt;

  riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_data(if_data),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                          input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [XLEN-1:0] mem_model [logic [XLEN-1:0]];
  logic            cap_en = 1'b0, cap_we = 1'b0;
  logic [XLEN-1:0] cap_addr = '0, cap_wdata = '0;

  function automatic logic [XLEN-1:0] mem_read(input logic [XLEN-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Read data appears the cycle after the strobe; otherwise the bus carries garbage
  always @(posedge clk) begin
    if (cap_en && !cap_we) mem_rdata <= mem_read(cap_addr);
    else                   mem_rdata <= $urandom;
    if (cap_en && cap_we) mem_model[cap_addr] = cap_wdata;
  end

  // ---------------- arbitration model + scoreboard ----------------
  logic [XLEN:0]   exp_q[$];   // {is_data, expected response word}
  logic [1:0]      m_state = 2'd0;
  int              m_cnt = 0;
  logic            m_gi, m_gd;
  logic [XLEN:0]   m_e;

  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_ctl", XLEN'({if_ready, if_valid, d_ready, d_valid,
                                 mem_en, mem_we, stall}), '0);
      check_eq("rst_data", if_data | d_rdata | mem_addr | mem_wdata, '0);
      check_eq("rst_dbg", XLEN'({dbg_state, dbg_starve_cnt}), '0);
      m_state = 2'd0;
      m_cnt   = 0;
      exp_q.delete();
      cap_en  = 1'b0;
      cap_we  = 1'b0;
    end else begin
      m_gi = (m_state == 2'd0) && if_req && (!d_req || (m_cnt == SM));
      m_gd = (m_state == 2'd0) && d_req && !m_gi;
      check_eq("state", XLEN'(dbg_state), XLEN'(m_state));
      check_eq("starve", XLEN'(dbg_starve_cnt), XLEN'(m_cnt));
      check_eq("if_ready", XLEN'(if_ready), XLEN'(m_gi));
      check_eq("d_ready", XLEN'(d_ready), XLEN'(m_gd));
      check_eq("stall", XLEN'(stall), XLEN'(if_req && !m_gi));
      check_eq("mem_en", XLEN'(mem_en), XLEN'(m_gi || m_gd));
      check_eq("mem_we", XLEN'(mem_we), XLEN'(m_gd && d_write));
      check_eq("mem_addr", mem_addr, m_gi ? if_addr : (m_gd ? d_addr : '0));
      check_eq("mem_wdata", mem_wdata, m_gd ? d_wdata : '0);
      if (m_gi) exp_q.push_back({1'b0, mem_read(if_addr)});
      if (m_gd) exp_q.push_back({1'b1, d_write ? '0 : mem_read(d_addr)});

      if (m_state != 2'd0) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_empty", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          check_eq("if_valid", XLEN'(if_valid), XLEN'(!m_e[XLEN]));
          check_eq("d_valid", XLEN'(d_valid), XLEN'(m_e[XLEN]));
          check_eq("if_data", if_data, m_e[XLEN] ? '0 : m_e[XLEN-1:0]);
          check_eq("d_rdata", d_rdata, m_e[XLEN] ? m_e[XLEN-1:0] : '0);
        end
      end else begin
        check_eq("idle_resp", XLEN'({if_valid, d_valid}) | if_data | d_rdata, '0);
      end

      cap_en    = mem_en;
      cap_we    = mem_we;
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;

      if (m_state != 2'd0) begin
        m_state = 2'd0;
      end else if (m_gi) begin
        m_state = 2'd1;
        m_cnt   = 0;
      end else if (m_gd) begin
        m_state = 2'd2;
        if (if_req && m_cnt < SM) m_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_write = 1'b0;
  endtask

  logic [7:0] got_seq;
  int         n_stall;

  initial begin
    mem_model[32'h10]  = 32'h0050_0093;
    mem_model[32'h200] = 32'h1234_5678;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_state", XLEN'(dbg_state), 0);
    tick();

    // fetch alone
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check_eq("f_mem_en", XLEN'(mem_en), 1);
    check_eq("f_mem_addr", mem_addr, 32'h10);
    check_eq("f_mem_we", XLEN'(mem_we), 0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check_eq("f_valid", XLEN'(if_valid), 1);
    check_eq("f_data", if_data, 32'h0050_0093);
    tick();

    // store; d_write flips during the response and must not matter
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("s_mem_we", XLEN'(mem_we), 1);
    check_eq("s_mem_addr", mem_addr, 32'h100);
    check_eq("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0; d_write = 1'b0;
    @(negedge clk);
    check_eq("s_valid", XLEN'(d_valid), 1);
    check_eq("s_rdata", d_rdata, 0);
    tick();

    // load; d_write flips high during the response
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h200;
    @(negedge clk);
    check_eq("l_ready", XLEN'(d_ready), 1);
    tick();
    d_req = 1'b0; d_write = 1'b1;
    @(negedge clk);
    check_eq("l_valid", XLEN'(d_valid), 1);
    check_eq("l_rdata", d_rdata, 32'h1234_5678);
    tick();
    idle_inputs();

    // contention straight out of reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_write = 1'b0;
    if_addr = 32'h40; d_addr = 32'h80;
    got_seq = '0;
    n_stall = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (if_ready || d_ready) got_seq = {got_seq[6:0], if_ready};
      if (stall) n_stall++;
      if (i == 0) check_eq("first_is_data", XLEN'(d_ready), 1);
      if (i == 1) check_eq("first_starve", XLEN'(dbg_starve_cnt), 1);
      tick();
    end
    check_eq("grant_order", XLEN'(got_seq), 32'h11);
    check_eq("stall_cycles", XLEN'(n_stall), 14);
    idle_inputs();
    tick();

    // reset while a load response is pending
    if_req = 1'b1; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h200;
    @(negedge clk);
    check_eq("r_grant_d", XLEN'(d_ready), 1);
    tick();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check_eq("r_valid_in_rst", XLEN'(d_valid), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("r_state", XLEN'(dbg_state), 0);
    check_eq("r_starve", XLEN'(dbg_starve_cnt), 0);
    check_eq("r_no_valid", XLEN'(d_valid), 0);
    tick();
    @(negedge clk);
    check_eq("r_no_late_valid", XLEN'(d_valid | if_valid), 0);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      if_req  = $urandom_range(0, 1);
      d_req   = $urandom_range(0, 1);
      d_write = $urandom_range(0, 1);
      if_addr = XLEN'({$urandom_range(0, 15), 2'b00});
      d_addr  = XLEN'({$urandom_range(0, 15), 2'b00});
      d_wdata = $urandom;
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check_eq("sb_drained", XLEN'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address and data width.
REQ-002 The block SHALL have parameter STARVE_MAX, default 3, meaning the maximum consecutive data grants while a fetch waits.
REQ-003 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port if_req  in  1  instruction fetch request.
REQ-006 The block SHALL have port if_addr  in  XLEN  fetch address (pc).
REQ-007 The block SHALL have port if_ready  out  1  fetch request accepted this cycle.
REQ-008 The block SHALL have port if_valid  out  1  fetch data valid this cycle.
REQ-009 The block SHALL have port if_data  out  XLEN  fetched instruction word.
REQ-010 The block SHALL have port d_req  in  1  data access request.
REQ-011 The block SHALL have port d_write  in  1  1 = store, 0 = load.
REQ-012 The block SHALL have port d_addr  in  XLEN  data address.
REQ-013 The block SHALL have port d_wdata  in  XLEN  store data.
REQ-014 The block SHALL have port d_ready  out  1  data request accepted this cycle.
REQ-015 The block SHALL have port d_valid  out  1  load data or store acknowledge valid this cycle.
REQ-016 The block SHALL have port d_rdata  out  XLEN  load data.
REQ-017 The block SHALL have port mem_en  out  1  memory access strobe.
REQ-018 The block SHALL have port mem_we  out  1  memory write enable.
REQ-019 The block SHALL have port mem_addr  out  XLEN  memory address.
REQ-020 The block SHALL have port mem_wdata  out  XLEN  memory write data.
REQ-021 The block SHALL have port mem_rdata  in  XLEN  memory read data, valid the cycle after mem_en.
REQ-022 The block SHALL have port stall  out  1  high when if_req is high and if_ready is low.

Function
REQ-023 The FSM SHALL have states IDLE, RESP_I and RESP_D.
REQ-024 In IDLE, when any request is present, the block SHALL grant exactly one requester, raise that requester's ready, and move to RESP_I or RESP_D for the winner.
REQ-025 Arbitration SHALL prefer data, unless if_req is high and starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-026 starve_cnt SHALL increment on each data grant made while if_req is high, saturate at STARVE_MAX, and clear on any fetch grant.
REQ-027 In the grant cycle, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be driven combinationally from the winner's inputs: fetch gives mem_we=0, data gives mem_we=d_write.
REQ-028 Outside a grant cycle, mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-029 In RESP_I, if_valid SHALL be 1 and if_data SHALL equal mem_rdata; the FSM SHALL then return to IDLE.
REQ-030 In RESP_D, d_valid SHALL be 1; d_rdata SHALL equal mem_rdata for a load and 0 for a store; the FSM SHALL then return to IDLE.
REQ-031 The store/load type SHALL be registered at grant, so that d_write changes during RESP_D do not affect d_rdata.
REQ-032 Both ready signals SHALL be 0 in RESP_I and RESP_D; throughput SHALL be one access per 2 cycles and latency SHALL be grant-to-valid = 1 cycle.
REQ-033 When no request is present in IDLE, the FSM SHALL stay in IDLE and starve_cnt SHALL be unchanged.
REQ-034 When both requests arrive simultaneously with starve_cnt < STARVE_MAX, data SHALL win and stall SHALL be 1.
REQ-035 Outside RESP_I and RESP_D respectively, if_valid, d_valid, if_data and d_rdata SHALL be 0.

Reset
REQ-036 When rst=1 at a clock edge, the block SHALL set state=IDLE and starve_cnt=0, overriding any in-flight response.
REQ-037 A response interrupted by reset SHALL produce no valid pulse after reset deasserts.
REQ-038 While rst=1, all outputs SHALL be 0.

Verification
REQ-039 Fetch alone: if_req=1, if_addr=0x10, mem_rdata=0x00500093 -> mem_en=1 with mem_addr=0x10 in the grant cycle; if_valid=1 and if_data=0x00500093 the next cycle.
REQ-040 Store: d_req=1, d_write=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1 with mem_addr=0x100 and mem_wdata=0xDEADBEEF; d_valid=1 and d_rdata=0 the next cycle.
REQ-041 Contention: if_req and d_req held high continuously, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I; stall=1 in every cycle without a fetch grant.
REQ-042 Simultaneous first request: both requests high after reset -> data granted first; starve_cnt=1.
REQ-043 Reset mid-operation: rst=1 during RESP_D -> next cycle state=IDLE, d_valid=0, starve_cnt=0.
REQ-044 Load: d_req=1, d_write=0, d_addr=0x200, mem_rdata=0x12345678 -> d_valid=1 and d_rdata=0x12345678 one cycle after the grant.
